// File: rtl/minimig_host_bus_arbiter.sv
// Shares the CPU-side bus between the 68SEC000 and the UserIO host port.
// The CPU is halted and seen idle before host transfers run; it is released after an idle window.
module minimig_host_bus_arbiter #(
  parameter int SETTLE    = 2,
  parameter int IDLE_HOLD = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        clk7_en,
  input  logic        cpu_as,
  input  logic        hold,
  input  logic        req,
  input  logic        req_we,
  input  logic [22:0] req_adr,
  input  logic [1:0]  req_bs,
  input  logic [15:0] req_wdat,
  output logic        req_ack,
  output logic        req_err,
  output logic [15:0] req_rdat,
  output logic        busy,
  output logic        cpu_halt,
  output logic        host_cs,
  output logic [22:0] host_adr,
  output logic        host_we,
  output logic [1:0]  host_bs,
  output logic [15:0] host_wdat,
  input  logic [15:0] host_rdat,
  input  logic        host_ack
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int IW = $clog2(IDLE_HOLD + 1);
  localparam int TW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_HALT_WAIT, S_READY, S_XFER, S_GAP, S_RELEASE
  } state_t;

  state_t      r_state;
  logic [SW-1:0] r_settle;
  logic [IW-1:0] r_idle;
  logic [TW-1:0] r_tmo;
  logic        r_halt, r_cs, r_ack, r_err, r_we;
  logic [22:0] r_adr;
  logic [1:0]  r_bs;
  logic [15:0] r_wdat, r_rdat;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
      r_idle   <= '0;
      r_tmo    <= '0;
      r_halt   <= 1'b0;
      r_cs     <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_bs     <= '0;
      r_wdat   <= '0;
      r_rdat   <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req || hold) begin
            r_halt   <= 1'b1;
            r_settle <= '0;
            r_state  <= S_HALT_WAIT;
          end
        end
        // Bus counts as ours only after SETTLE consecutive idle samples of AS.
        S_HALT_WAIT: begin
          if (clk7_en) begin
            if (!cpu_as) begin
              r_settle <= '0;
            end else if (r_settle == SW'(SETTLE - 1)) begin
              r_settle <= '0;
              r_idle   <= '0;
              r_state  <= S_READY;
            end else begin
              r_settle <= r_settle + SW'(1);
            end
          end
        end
        S_READY: begin
          if (req) begin
            r_we    <= req_we;
            r_adr   <= req_adr;
            r_bs    <= req_bs;
            r_wdat  <= req_wdat;
            r_tmo   <= '0;
            r_idle  <= '0;
            r_cs    <= 1'b1;
            r_state <= S_XFER;
          end else if (hold) begin
            r_idle <= '0;
          end else if (clk7_en) begin
            if (r_idle == IW'(IDLE_HOLD - 1)) begin
              r_idle  <= '0;
              r_halt  <= 1'b0;
              r_state <= S_RELEASE;
            end else begin
              r_idle <= r_idle + IW'(1);
            end
          end
        end
        // Acknowledge is checked first so it wins over a coincident timeout.
        S_XFER: begin
          if (host_ack) begin
            if (!r_we) r_rdat <= host_rdat;
            r_ack   <= 1'b1;
            r_cs    <= 1'b0;
            r_state <= S_GAP;
          end else if (clk7_en) begin
            if (r_tmo == TW'(TIMEOUT - 1)) begin
              if (!r_we) r_rdat <= 16'hFFFF;
              r_ack   <= 1'b1;
              r_err   <= 1'b1;
              r_cs    <= 1'b0;
              r_state <= S_GAP;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
        end
        S_GAP: begin
          if (!host_ack) begin
            r_idle  <= '0;
            r_state <= S_READY;
          end
        end
        S_RELEASE: begin
          if (clk7_en) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign cpu_halt  = r_halt;
  assign host_cs   = r_cs;
  assign host_adr  = r_adr;
  assign host_we   = r_we;
  assign host_bs   = r_bs;
  assign host_wdat = r_wdat;
  assign req_ack   = r_ack;
  assign req_err   = r_err;
  assign req_rdat  = r_rdat;

endmodule

// File: tb/tb_minimig_host_bus_arbiter.sv
// Bench for minimig_host_bus_arbiter: transaction-level reference with a timed bridge model.
module tb_minimig_host_bus_arbiter;
  localparam int SETTLE = 2, IDLE_HOLD = 16, TIMEOUT = 255;

  logic        clk = 0, rst_n = 0, clk7_en = 0, cpu_as = 1, hold = 0, req = 0;
  logic        req_we = 0, host_ack = 0;
  logic [22:0] req_adr = '0;
  logic [1:0]  req_bs = '0;
  logic [15:0] req_wdat = '0, host_rdat = '0;
  logic        req_ack, req_err, busy, cpu_halt, host_cs, host_we;
  logic [15:0] req_rdat, host_wdat;
  logic [22:0] host_adr;
  logic [1:0]  host_bs;

  minimig_host_bus_arbiter #(.SETTLE(SETTLE), .IDLE_HOLD(IDLE_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), ._reset(rst_n), .clk7_en(clk7_en), .cpu_as(cpu_as), .hold(hold),
    .req(req), .req_we(req_we), .req_adr(req_adr), .req_bs(req_bs), .req_wdat(req_wdat),
    .req_ack(req_ack), .req_err(req_err), .req_rdat(req_rdat), .busy(busy),
    .cpu_halt(cpu_halt), .host_cs(host_cs), .host_adr(host_adr), .host_we(host_we),
    .host_bs(host_bs), .host_wdat(host_wdat), .host_rdat(host_rdat), .host_ack(host_ack)
  );

  always #5 clk = ~clk;

  logic [1:0] ph = 0;
  always @(negedge clk) begin
    ph = ph + 2'd1;
    clk7_en = (ph == 2'd0);
  end

  int n_chk = 0, n_err = 0;
  int settle = 0, halt_drops = 0, cs_rises = 0, acks = 0;
  bit fresh = 0;
  logic [15:0] rdat_model = 16'h0000;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One clock: observe the edge, then sample outputs 1ns later; track bus-level events.
  task automatic tick(output bit en);
    logic p_halt, p_cs, p_as;
    p_halt = cpu_halt; p_cs = host_cs; p_as = cpu_as;
    @(posedge clk);
    en = clk7_en;
    #1;
    if (en) settle = (p_halt && p_as) ? settle + 1 : 0;
    if (!p_halt && cpu_halt) begin fresh = 1; settle = 0; end
    if (p_halt && !cpu_halt) halt_drops++;
    if (!p_cs && host_cs) cs_rises++;
    if (req_ack) acks++;
  endtask

  task automatic do_xfer(input bit we, input logic [22:0] adr, input logic [1:0] bs,
                         input logic [15:0] wd, input logic [15:0] rd, input int lat,
                         input int busy_n);
    bit en, was_idle, to;
    int cnt, t, t_set;
    was_idle = !busy;
    cpu_as = (busy_n == 0);
    req_we = we; req_adr = adr; req_bs = bs; req_wdat = wd; req = 1;
    t = 0;
    do begin
      tick(en); t++;
      if (t == 1 && was_idle) chk("halt_rise", cpu_halt, 1);
      if (en && busy_n > 0) begin busy_n--; if (busy_n == 0) cpu_as = 1; end
    end while (!host_cs && t < 3000);
    chk("cs_seen", host_cs, 1);
    chk("cs_halted", cpu_halt, 1);
    chk("adr", host_adr, adr);
    chk("we", host_we, we);
    chk("bs", host_bs, bs);
    chk("wdat", host_wdat, wd);
    chk("busy", busy, 1);
    if (fresh) begin chk("settle", settle, SETTLE); fresh = 0; end
    cnt = 0; t = 0; t_set = 0;
    do begin
      tick(en); t++;
      if (en) cnt++;
      if (!req_ack && !host_ack && cnt == lat) begin
        host_rdat = rd; host_ack = 1; t_set = t;
      end
    end while (!req_ack && t < 3000);
    to = (lat >= TIMEOUT);
    if (!we) rdat_model = to ? 16'hFFFF : rd;
    chk("ack", req_ack, 1);
    chk("err", req_err, to);
    chk("rdat", req_rdat, rdat_model);
    chk("cs_drop", host_cs, 0);
    chk("ack_lat", cnt, to ? TIMEOUT : lat);
    if (!to) chk("ack_delay", t - t_set, 1);
    host_ack = 0; req = 0;
    tick(en);
    chk("ack_pulse", req_ack, 0);
    chk("rdat_hold", req_rdat, rdat_model);
  endtask

  // Counts clk7_en periods of idle READY until the halt is dropped, then waits for IDLE.
  task automatic wait_release();
    bit en;
    int cnt, t;
    cnt = 0; t = 0;
    do begin tick(en); t++; if (en) cnt++; end while (cpu_halt && t < 1000);
    chk("idle_hold", cnt, IDLE_HOLD);
    t = 0;
    do begin tick(en); t++; end while (busy && t < 100);
    chk("released_idle", {busy, cpu_halt, host_cs}, 0);
  endtask

  initial begin
    bit en;
    int d0, c0, a0, n;
    repeat (3) tick(en);
    chk("rst_outs", {req_ack, req_err, req_rdat, busy, cpu_halt, host_cs,
                     host_adr, host_we, host_bs, host_wdat}, 0);
    rst_n = 1;
    repeat (4) tick(en);
    chk("idle_quiet", {busy, cpu_halt}, 0);

    // single read with an idle CPU
    do_xfer(0, 23'h7C0000, 2'b11, 16'h0, 16'hA5A5, 3, 0);
    wait_release();

    // CPU busy for 10 periods after the request
    do_xfer(1, 23'h012345, 2'b01, 16'hBEEF, 16'h0, 2, 10);
    wait_release();

    // burst of writes keeps the CPU halted
    d0 = halt_drops; c0 = cs_rises; a0 = acks;
    for (int i = 1; i <= 4; i++)
      do_xfer(1, 23'h100000 + 23'(i), 2'b10, 16'(i), 16'h0, 1 + (i % 3), 0);
    chk("burst_halt", halt_drops - d0, 0);
    chk("burst_cs", cs_rises - c0, 4);
    chk("burst_ack", acks - a0, 4);
    wait_release();

    // timeout, then a normal read
    do_xfer(0, 23'h000777, 2'b11, 16'h0, 16'h1234, 1000, 0);
    do_xfer(0, 23'h000778, 2'b11, 16'h0, 16'h5678, 2, 0);
    wait_release();

    // hold without a request
    hold = 1;
    d0 = halt_drops; c0 = cs_rises;
    repeat (200) tick(en);
    chk("hold_halt", cpu_halt, 1);
    chk("hold_nodrop", halt_drops - d0, 0);
    chk("hold_nocs", cs_rises - c0, 0);
    hold = 0;
    wait_release();

    // randomized groups
    for (int g = 0; g < 4; g++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++)
        do_xfer(1'($urandom), 23'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(1, 8), (k == 0) ? $urandom_range(0, 4) : 0);
      wait_release();
    end

    // reset during a transfer
    req_we = 0; req_adr = 23'h055555; req_bs = 2'b11; req = 1;
    n = 0;
    do begin tick(en); n++; end while (!host_cs && n < 200);
    chk("pre_rst_cs", host_cs, 1);
    repeat (3) tick(en);
    #2 rst_n = 0;
    #1;
    chk("rst_async", {host_cs, cpu_halt, busy}, 0);
    req = 0; fresh = 0;
    tick(en);
    rst_n = 1;
    a0 = acks;
    repeat (20) tick(en);
    chk("rst_noack", acks - a0, 0);
    chk("rst_state", {busy, cpu_halt, req_rdat}, 0);

    // bus usable again after reset
    rdat_model = 16'h0000;
    do_xfer(0, 23'h7C0001, 2'b11, 16'h0, 16'hC3C3, 4, 0);
    wait_release();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
